// File: rtl/cache_pkg.sv
// Shared types for the cache miss handler: widths, FSM states and the latched request.
// CACHE_WRITEBACK_EN selects the write-back state set; otherwise a write-through store state is used.
package cache_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = 2;
  localparam int INDEX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef CACHE_WRITEBACK_EN
    S_WB   = 3'd1,
`else
    S_WT   = 3'd1,
`endif
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_FILL = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic [DATA_W-1:0] data;
  } req_t;

  // Victim line address: victim's tag on top of the request's index.
  function automatic logic [ADDR_W-1:0] victim_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [ADDR_W-1:0] addr);
    return {tag, addr[INDEX_W-1:0]};
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// 4-bit loadable down-counter; done marks the last cycle of the memory read latency.
module mem_lat_counter (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] count_r;

  // Load on the read strobe, count down while waiting, saturate at zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end
  end

  assign done = (count_r == 4'd1);

endmodule

// File: rtl/cache_miss_handler.sv
// Miss-service controller: optional victim write-back, memory fetch, refill and response.
// Define CACHE_WRITEBACK_EN for the write-back cache; the default build is write-through.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wren,
  input  logic [DATA_W-1:0] req_data,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [DATA_W-1:0] victim_data,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              fill_en,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_dirty,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAT_VAL = 4'(MEM_LAT);

  state_t            state_r;
  state_t            state_next_s;
  req_t              req_r;
  logic [DATA_W-1:0] line_r;
  logic              accept_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_done_s;

`ifdef CACHE_WRITEBACK_EN
  logic [TAG_W-1:0]  vtag_r;
  logic [DATA_W-1:0] vdata_r;
`else
  logic              unused_victim_s;
  assign unused_victim_s = ^{victim_valid, victim_dirty, victim_tag, victim_data};
`endif

  assign accept_s = (state_r == S_IDLE) && req_valid;

  mem_lat_counter u_lat_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .load     (cnt_load_s),
    .load_val (LAT_VAL),
    .dec      (cnt_dec_s),
    .done     (cnt_done_s)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request and victim latch, loaded only on acceptance so later req_* changes are ignored.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req_r   <= '0;
`ifdef CACHE_WRITEBACK_EN
      vtag_r  <= '0;
      vdata_r <= '0;
`endif
    end else if (accept_s) begin
      req_r.addr <= req_addr;
      req_r.wren <= req_wren;
      req_r.data <= req_data;
`ifdef CACHE_WRITEBACK_EN
      vtag_r     <= victim_tag;
      vdata_r    <= victim_data;
`endif
    end
  end

  // Line register captures memory data on the last latency cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      line_r <= '0;
    end else if ((state_r == S_WAIT) && cnt_done_s) begin
      line_r <= mem_rdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
`ifdef CACHE_WRITEBACK_EN
          if (victim_valid && victim_dirty) begin
            state_next_s = S_WB;
          end else if (req_wren) begin
            state_next_s = S_FILL;
          end else begin
            state_next_s = S_RD;
          end
`else
          if (req_wren) begin
            state_next_s = S_WT;
          end else begin
            state_next_s = S_RD;
          end
`endif
        end else begin
          state_next_s = S_IDLE;
        end
      end
`ifdef CACHE_WRITEBACK_EN
      S_WB:   state_next_s = req_r.wren ? S_FILL : S_RD;
`else
      S_WT:   state_next_s = S_FILL;
`endif
      S_RD:   state_next_s = S_WAIT;
      S_WAIT: state_next_s = cnt_done_s ? S_FILL : S_WAIT;
      S_FILL: state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode: every output is a function of registered state only.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    fill_en    = 1'b0;
    fill_tag   = '0;
    fill_data  = '0;
    fill_dirty = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      S_IDLE: req_ready = 1'b1;
`ifdef CACHE_WRITEBACK_EN
      S_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = victim_addr(vtag_r, req_r.addr);
        mem_wdata = vdata_r;
      end
`else
      S_WT: begin
        mem_wr    = 1'b1;
        mem_addr  = req_r.addr;
        mem_wdata = req_r.data;
      end
`endif
      S_RD: begin
        mem_rd     = 1'b1;
        mem_addr   = req_r.addr;
        cnt_load_s = 1'b1;
      end
      S_WAIT: cnt_dec_s = 1'b1;
      S_FILL: begin
        fill_en    = 1'b1;
        resp_valid = 1'b1;
        fill_tag   = req_r.addr[ADDR_W-1:INDEX_W];
        fill_data  = req_r.wren ? req_r.data : line_r;
        resp_data  = req_r.wren ? req_r.data : line_r;
`ifdef CACHE_WRITEBACK_EN
        fill_dirty = req_r.wren;
`else
        fill_dirty = 1'b0;
`endif
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench: two handler instances (MEM_LAT 1 and 4) checked cycle by cycle against a transaction model.
module tb_cache_miss_handler;
  import cache_pkg::*;

`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  typedef struct packed {
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       fill_en;
    logic [1:0] fill_tag;
    logic [7:0] fill_data;
    logic       fill_dirty;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
  } obs_t;

  typedef struct {
    int         inst;
    logic [4:0] addr;
    logic       wren;
    logic [7:0] data;
    logic       vv;
    logic       vd;
    logic [1:0] vtag;
    logic [7:0] vdata;
    logic [7:0] memval;
    int         exp_lat;
    logic [7:0] exp_resp;
    logic       exp_dirty;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic [1:0] req_valid;
  logic [4:0] req_addr;
  logic       req_wren;
  logic [7:0] req_data;
  logic       victim_valid, victim_dirty;
  logic [1:0] victim_tag;
  logic [7:0] victim_data;
  logic [7:0] mem_rdata;

  logic       req_ready [2];
  logic       resp_valid [2];
  logic [7:0] resp_data [2];
  logic       fill_en [2];
  logic [1:0] fill_tag [2];
  logic [7:0] fill_data [2];
  logic       fill_dirty [2];
  logic       mem_rd [2];
  logic       mem_wr [2];
  logic [4:0] mem_addr [2];
  logic [7:0] mem_wdata [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cache_miss_handler #(.MEM_LAT(1)) u_lat1 (
    .clock(clock), .resetn(resetn), .req_valid(req_valid[0]), .req_addr(req_addr),
    .req_wren(req_wren), .req_data(req_data), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
    .fill_en(fill_en[0]), .fill_tag(fill_tag[0]), .fill_data(fill_data[0]),
    .fill_dirty(fill_dirty[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata)
  );

  cache_miss_handler #(.MEM_LAT(4)) u_lat4 (
    .clock(clock), .resetn(resetn), .req_valid(req_valid[1]), .req_addr(req_addr),
    .req_wren(req_wren), .req_data(req_data), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
    .fill_en(fill_en[1]), .fill_tag(fill_tag[1]), .fill_data(fill_data[1]),
    .fill_dirty(fill_dirty[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata)
  );

  function automatic int lat_of(input int inst);
    return (inst == 1) ? 4 : 1;
  endfunction

  function automatic vec_t mk(input int inst, input logic [4:0] addr, input logic wren,
                              input logic [7:0] data, input logic vv, input logic vd,
                              input logic [1:0] vtag, input logic [7:0] vdata,
                              input logic [7:0] memval, input int exp_lat,
                              input logic [7:0] exp_resp, input logic exp_dirty);
    vec_t v;
    v.inst = inst; v.addr = addr; v.wren = wren; v.data = data; v.vv = vv; v.vd = vd;
    v.vtag = vtag; v.vdata = vdata; v.memval = memval; v.exp_lat = exp_lat;
    v.exp_resp = exp_resp; v.exp_dirty = exp_dirty;
    return v;
  endfunction

  // Transaction-level model: cycle offsets of each memory/fill event after acceptance.
  function automatic bit model_wb(input vec_t v);
    return WB_EN && v.vv && v.vd;
  endfunction

  function automatic int model_rd(input vec_t v);
    if (v.wren) return -1;
    return model_wb(v) ? 2 : 1;
  endfunction

  function automatic int model_fill(input vec_t v, input int lat);
    if (v.wren) return (model_wb(v) || !WB_EN) ? 2 : 1;
    return model_rd(v) + 1 + lat;
  endfunction

  function automatic int model_sample(input vec_t v, input int lat);
    if (v.wren) return -1;
    return model_rd(v) + lat;
  endfunction

  function automatic obs_t model_obs(input vec_t v, input int lat, input int k);
    obs_t o = '0;
    if (k == 0) o.req_ready = 1'b1;
    if (k == 1 && model_wb(v)) begin
      o.mem_wr = 1'b1; o.mem_addr = {v.vtag, v.addr[2:0]}; o.mem_wdata = v.vdata;
    end
    if (k == 1 && !WB_EN && v.wren) begin
      o.mem_wr = 1'b1; o.mem_addr = v.addr; o.mem_wdata = v.data;
    end
    if (k == model_rd(v)) begin
      o.mem_rd = 1'b1; o.mem_addr = v.addr;
    end
    if (k == model_fill(v, lat)) begin
      o.fill_en = 1'b1; o.resp_valid = 1'b1; o.fill_tag = v.addr[4:3];
      o.fill_data = v.wren ? v.data : v.memval;
      o.resp_data = o.fill_data;
      o.fill_dirty = WB_EN && v.wren;
    end
    return o;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o.req_ready = req_ready[i]; o.resp_valid = resp_valid[i]; o.resp_data = resp_data[i];
    o.fill_en = fill_en[i]; o.fill_tag = fill_tag[i]; o.fill_data = fill_data[i];
    o.fill_dirty = fill_dirty[i]; o.mem_rd = mem_rd[i]; o.mem_wr = mem_wr[i];
    o.mem_addr = mem_addr[i]; o.mem_wdata = mem_wdata[i];
    return o;
  endfunction

  task automatic check_obs(input string name, input int k, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid_on);
    req_valid = 2'b00;
    req_valid[v.inst] = valid_on;
    req_addr = v.addr; req_wren = v.wren; req_data = v.data;
    victim_valid = v.vv; victim_dirty = v.vd; victim_tag = v.vtag; victim_data = v.vdata;
  endtask

  // One accepted miss, checked every cycle from acceptance to FILL; hold keeps a second request pending.
  task automatic run_txn(input string name, input vec_t v, input bit hold, input vec_t nxt,
                         output int fill_at, output logic [7:0] resp_at, output logic dirty_at);
    int lat = lat_of(v.inst);
    int fc = model_fill(v, lat);
    int ms = model_sample(v, lat);
    obs_t act;
    fill_at = -1; resp_at = 8'h00; dirty_at = 1'b0;
    for (int k = 0; k <= fc; k++) begin
      @(negedge clock);
      if (k == 0) drive(v, 1'b1);
      else if (hold) drive(nxt, 1'b1);
      else drive(v, 1'b0);
      mem_rdata = (k == ms) ? v.memval : ~v.memval;
      #1;
      act = get_obs(v.inst);
      check_obs(name, k, act, model_obs(v, lat, k));
      if (act.fill_en === 1'b1 && fill_at < 0) begin
        fill_at = k; resp_at = act.resp_data; dirty_at = act.fill_dirty;
      end
    end
  endtask

  vec_t tbl [7];
  vec_t none;

  initial begin
    int fa;
    logic [7:0] ra;
    logic da;
    obs_t idle;
    vec_t v, v2;

    idle = '0;
    idle.req_ready = 1'b1;
    none = mk(0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 1'b0);

    tbl[0] = mk(0, 5'b10110, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 8'hA5, 3, 8'hA5, 1'b0);
    tbl[1] = mk(0, 5'b11110, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 8'h3C, 8'h5A,
                WB_EN ? 4 : 3, 8'h5A, 1'b0);
    tbl[2] = mk(0, 5'b00011, 1'b0, 8'h00, 1'b0, 1'b1, 2'b11, 8'hEE, 8'hC3, 3, 8'hC3, 1'b0);
    tbl[3] = mk(0, 5'b01001, 1'b1, 8'h7E, 1'b1, 1'b0, 2'b10, 8'h11, 8'h00,
                WB_EN ? 1 : 2, 8'h7E, WB_EN);
    tbl[4] = mk(0, 5'b10101, 1'b1, 8'h81, 1'b1, 1'b1, 2'b11, 8'h99, 8'h00, 2, 8'h81, WB_EN);
    tbl[5] = mk(1, 5'b00111, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 8'h4D, 6, 8'h4D, 1'b0);
    tbl[6] = mk(1, 5'b01100, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 8'hB2, 8'h17,
                WB_EN ? 7 : 6, 8'h17, 1'b0);

    // Reset: both instances idle with only req_ready high.
    resetn = 1'b0;
    drive(none, 1'b0);
    mem_rdata = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    check_obs("reset_lat1", 0, get_obs(0), idle);
    check_obs("reset_lat4", 0, get_obs(1), idle);
    @(negedge clock);
    resetn = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i], 1'b0, none, fa, ra, da);
      check_int($sformatf("vec%0d_latency", i), fa, tbl[i].exp_lat);
      check_int($sformatf("vec%0d_resp", i), int'(ra), int'(tbl[i].exp_resp));
      check_int($sformatf("vec%0d_dirty", i), int'(da), int'(tbl[i].exp_dirty));
    end

    // Busy: a second request held high during WAIT is taken only after FILL.
    v  = mk(1, 5'b11011, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 8'h3A, 6, 8'h3A, 1'b0);
    v2 = mk(1, 5'b01010, 1'b1, 8'h66, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00,
            WB_EN ? 1 : 2, 8'h66, WB_EN);
    run_txn("busy_first", v, 1'b1, v2, fa, ra, da);
    check_int("busy_first_resp", int'(ra), 8'h3A);
    run_txn("busy_second", v2, 1'b0, none, fa, ra, da);
    check_int("busy_second_latency", fa, v2.exp_lat);
    check_int("busy_second_resp", int'(ra), 8'h66);

    // Reset mid-WAIT aborts the miss with no fill or response.
    @(negedge clock); drive(tbl[5], 1'b1); mem_rdata = 8'h00;
    @(negedge clock); drive(tbl[5], 1'b0);
    @(negedge clock);
    #1 check_obs("in_wait", 2, get_obs(1), '0);
    @(negedge clock);
    resetn = 1'b0;
    #1 check_obs("reset_mid_wait", 3, get_obs(1), idle);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      #1 check_obs("post_reset_idle", k, get_obs(1), idle);
    end
    run_txn("after_reset", tbl[0], 1'b0, none, fa, ra, da);
    check_int("after_reset_resp", int'(ra), 8'hA5);

    // Randomized misses against the model.
    for (int i = 0; i < 40; i++) begin
      v = mk(int'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
             0, 8'h00, 1'b0);
      run_txn($sformatf("rand%0d", i), v, 1'b0, none, fa, ra, da);
      check_int($sformatf("rand%0d_latency", i), fa, model_fill(v, lat_of(v.inst)));
      check_int($sformatf("rand%0d_resp", i), int'(ra), int'(v.wren ? v.data : v.memval));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Miss-service controller on the memory side of the 2-way, 8-bit-data, 5-bit-address cache. It accepts one miss request at a time from the cache. When the victim way is dirty it first writes the victim back to main memory, then fetches the requested byte. It refills the chosen way and returns the data to the requester. It is the responder half of the cache's hit/miss interface and the only block that drives the main-memory port.

## Interface
- ADDR_W, 5, byte address width; tag = addr[4:3], index = addr[2:0]
- DATA_W, 8, data width; one byte per line
- MEM_LAT, 1, main-memory read latency in cycles; legal range 1..15
- clock  in  1  single clock; all state changes on the rising edge
- resetn  in  1  reset, asynchronous and active-low
- req_valid  in  1  cache reports a miss
- req_addr  in  ADDR_W  missing address
- req_wren  in  1  miss is a write
- req_data  in  DATA_W  write data for write misses
- victim_valid, victim_dirty  in  1 each  state of the victim way selected by the cache's replacement bit
- victim_tag  in  2  tag of the victim line
- victim_data  in  DATA_W  data of the victim line
- req_ready  out  1  request accepted this cycle if req_valid is high
- resp_valid  out  1  one-cycle pulse: miss serviced
- resp_data  out  DATA_W  fetched byte on reads; echoed req_data on writes
- fill_en  out  1  one-cycle pulse: write the victim way
- fill_tag  out  2  tag to write
- fill_data  out  DATA_W  data to write
- fill_dirty  out  1  dirty bit to write
- mem_rd, mem_wr  out  1 each  memory read strobe and memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, WB, RD, WAIT, FILL.
- IDLE: req_ready = 1.
  - On req_valid, latch req_*, victim_tag and victim_data.
  - Next state is WB if victim_valid && victim_dirty, otherwise RD for a read or FILL for a write.
- WB (one cycle):
  - mem_wr = 1, mem_addr = {victim_tag, index}, mem_wdata = victim_data.
  - Next state is RD for a read, FILL for a write.
- RD (one cycle): mem_rd = 1, mem_addr = latched req_addr. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the line register and go to FILL.
- FILL (one cycle): fill_en = 1, resp_valid = 1, fill_tag = req_addr[4:3], then IDLE.
  - Read miss: fill_data = resp_data = the captured byte, fill_dirty = 0.
  - Write miss: fill_data = resp_data = req_data, fill_dirty = 1. A write miss never reads memory (write-allocate, whole-line overwrite).
- Invalid victim: no WB, even when victim_dirty is high.
- Backpressure:
  - req_ready is 0 outside IDLE, and req_valid is ignored there.
  - The cache holds its request until it is accepted.
  - A new request can be accepted in the cycle after FILL, no earlier.
- mem_rd and mem_wr are never high in the same cycle.
- mem_addr and mem_wdata are 0 whenever both strobes are low.

## Timing
- Reset: asynchronous, returns to IDLE.
  - All outputs 0 except req_ready, which is 1.
  - Counter and latched registers are cleared.
- Reset during WB, RD, WAIT or FILL: the operation is aborted, no fill_en or resp_valid is issued, and the cache must re-request.
- Request accepted in cycle T. resp_valid and fill_en fire in:
  - Clean read miss: cycle T+2+MEM_LAT.
  - Dirty read miss: cycle T+3+MEM_LAT.
  - Clean write miss: cycle T+1.
  - Dirty write miss: cycle T+2.
- Memory is sampled exactly MEM_LAT cycles after the mem_rd cycle.

## Configuration
- CACHE_WRITEBACK_EN defined: write-back behaviour as described above.
- CACHE_WRITEBACK_EN undefined (write-through cache):
  - WB state and victim_dirty are removed; fill_dirty is always 0.
  - A write miss issues mem_wr with the req address and data in the cycle after acceptance, then FILL in the following cycle.
  - Write-miss latency is T+2.

## Structure
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, TAG_W = 2, INDEX_W = 3
  - the state enum typedef
  - a request struct typedef {addr, wren, data}
- One sub-module: mem_lat_counter, a 4-bit loadable down-counter with a done flag, used by WAIT.

## Test plan
- Reset: hold resetn = 0 for 3 cycles -> req_ready = 1, every other output 0.
- Clean read miss: MEM_LAT = 1, req_addr = 5'b10110, victim invalid, mem returns 8'hA5 -> mem_rd in T+1 with mem_addr = 5'b10110; fill_en and resp_valid in T+3 with resp_data = 8'hA5, fill_tag = 2'b10, fill_dirty = 0.
- Dirty read miss: victim_tag = 2'b01, victim_data = 8'h3C, index 3'b110 -> mem_wr in T+1 with mem_addr = 5'b01110, mem_wdata = 8'h3C; response in T+4.
- Write miss: clean victim, req_data = 8'h7E -> no memory access; fill_en in T+1 with fill_data = 8'h7E, fill_dirty = 1. Repeat with CACHE_WRITEBACK_EN undefined -> mem_wr in T+1, fill in T+2, fill_dirty = 0.
- Busy and reset: MEM_LAT = 4, second req_valid asserted during WAIT -> req_ready = 0 and the request is ignored until the cycle after FILL. Reset asserted mid-WAIT -> no fill_en or resp_valid, FSM returns to IDLE.
